// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared CP0 register numbers, write masks and interrupt FSM states
package cp0_pkg;

   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;

   localparam logic [31:0] STATUS_WMASK = 32'h0000FF01;
   localparam logic [31:0] CAUSE_WMASK  = 32'h00000300;

   typedef enum logic [1:0] {
      IDLE,
      TAKE,
      HOLD
   } int_state_t;

endpackage

// File: rtl/cp0_sync.sv
// rtl/cp0_sync.sv - multi-flop synchroniser for the asynchronous interrupt request lines
module cp0_sync #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/cp0_int_ctrl.sv
// rtl/cp0_int_ctrl.sv - CP0 Status/Cause/EPC responder and interrupt-take sequencer; CP0_TIMER_EN adds Count/Compare
module cp0_int_ctrl
   import cp0_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  cp0_addr,
   input  logic        cp0_we,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   input  logic [5:0]  hw_int,
   input  logic [31:0] pc_in,
   input  logic        int_ok,
   output logic        int_take
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   logic [5:0]  hw_sync;
   logic [31:0] status_q;
   logic [31:0] cause_sw_q;
   logic [31:0] epc_q;
   logic [31:0] cause_rd;
   logic        timer_flag;
   logic        we_q;
   logic        pending;
   logic        blackout;
   logic        wr_status;
   logic        wr_cause;
   logic [7:0]  hold_cnt;
   int_state_t  state;

   cp0_sync #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (6)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (hw_int),
      .q   (hw_sync)
   );

   assign wr_status = cp0_we && (cp0_addr == CP0_STATUS);
   assign wr_cause  = cp0_we && (cp0_addr == CP0_CAUSE);
   assign cause_rd  = cause_sw_q
                    | {16'b0, hw_sync[5] | timer_flag, hw_sync[4:0], 10'b0};
   assign pending   = status_q[0] & (|(cause_rd[15:8] & status_q[15:8]));
   // Any mtc0 and the cycle after it suppress a take, so the ISR's re-enable settles first.
   assign blackout  = cp0_we | we_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         status_q   <= '0;
         cause_sw_q <= '0;
         epc_q      <= '0;
         we_q       <= 1'b0;
         int_take   <= 1'b0;
         hold_cnt   <= '0;
         state      <= IDLE;
      end else begin
         we_q     <= cp0_we;
         int_take <= 1'b0;
         if (wr_status) status_q <= cp0_wdata & STATUS_WMASK;
         if (wr_cause) cause_sw_q <= cp0_wdata & CAUSE_WMASK;
         case (state)
            IDLE: begin
               if (pending && int_ok && !blackout) begin
                  state    <= TAKE;
                  int_take <= 1'b1;
                  epc_q    <= pc_in;
                  status_q <= status_q & ~32'h1;
               end
            end
            TAKE: begin
               hold_cnt <= '0;
               state    <= (HOLD_CYCLES == 0) ? IDLE : HOLD;
            end
            HOLD: begin
               if (hold_cnt == HOLD_LAST) state <= IDLE;
               else hold_cnt <= hold_cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CP0_TIMER_EN
   logic [31:0] count_q;
   logic [31:0] compare_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= '0;
         compare_q  <= 32'hFFFF_FFFF;
         timer_flag <= 1'b0;
      end else begin
         if (cp0_we && (cp0_addr == CP0_COUNT)) count_q <= cp0_wdata;
         else count_q <= count_q + 32'd1;
         // Writing Compare acknowledges the timer, and that wins over a same-cycle match.
         if (cp0_we && (cp0_addr == CP0_COMPARE)) begin
            compare_q  <= cp0_wdata;
            timer_flag <= 1'b0;
         end else if (count_q == compare_q) begin
            timer_flag <= 1'b1;
         end
      end
   end
`else
   assign timer_flag = 1'b0;
`endif

   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         CP0_STATUS:  cp0_rdata = status_q;
         CP0_CAUSE:   cp0_rdata = cause_rd;
         CP0_EPC:     cp0_rdata = epc_q;
`ifdef CP0_TIMER_EN
         CP0_COUNT:   cp0_rdata = count_q;
         CP0_COMPARE: cp0_rdata = compare_q;
`endif
         default:     cp0_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// tb/tb_cp0_int_ctrl.sv - self-checking bench for cp0_int_ctrl against a cycle-level behavioural model
module tb_cp0_int_ctrl;

   localparam int SYNC_STAGES = 2;
   localparam int HOLD_CYCLES = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  cp0_addr = '0;
   logic        cp0_we = 1'b0;
   logic [31:0] cp0_wdata = '0;
   logic [31:0] cp0_rdata;
   logic [5:0]  hw_int = '0;
   logic [31:0] pc_in = '0;
   logic        int_ok = 1'b0;
   logic        int_take;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   cp0_int_ctrl #(
      .SYNC_STAGES (SYNC_STAGES),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cp0_addr  (cp0_addr),
      .cp0_we    (cp0_we),
      .cp0_wdata (cp0_wdata),
      .cp0_rdata (cp0_rdata),
      .hw_int    (hw_int),
      .pc_in     (pc_in),
      .int_ok    (int_ok),
      .int_take  (int_take)
   );

   always #5 clk = ~clk;

   // Model state: architectural registers plus "cycles until a take may be decided again".
   logic [31:0] m_status, m_cause_sw, m_epc, m_count, m_compare;
   logic        m_take, m_we_prev, m_flag;
   logic [5:0]  hw_d [SYNC_STAGES];
   int          quiet;

   function automatic logic [31:0] m_cause();
      logic [31:0] c;
      c = m_cause_sw | (32'(hw_d[SYNC_STAGES-1]) << 10);
`ifdef CP0_TIMER_EN
      if (m_flag) c = c | 32'h8000;
`endif
      return c;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12: return m_status;
         5'd13: return m_cause();
         5'd14: return m_epc;
`ifdef CP0_TIMER_EN
         5'd9:  return m_count;
         5'd11: return m_compare;
`endif
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk) begin
      logic [31:0] c;
      bit pend, decide;
      if (rst) begin
         m_status = 0; m_cause_sw = 0; m_epc = 0; m_take = 0; m_we_prev = 0;
         m_count = 0; m_compare = 32'hFFFF_FFFF; m_flag = 0; quiet = 0;
         for (int i = 0; i < SYNC_STAGES; i++) hw_d[i] = 0;
      end else begin
         c = m_cause();
         pend = m_status[0] && ((c[15:8] & m_status[15:8]) != 0);
         decide = (quiet == 0) && pend && int_ok && !cp0_we && !m_we_prev;
         if (quiet > 0) quiet--;
         if (decide) begin
            quiet = 1 + HOLD_CYCLES;
            m_epc = pc_in;
            m_status[0] = 1'b0;
         end
         m_take = decide;
         if (cp0_we && cp0_addr == 5'd12) m_status = cp0_wdata & 32'h0000FF01;
         if (cp0_we && cp0_addr == 5'd13) m_cause_sw = cp0_wdata & 32'h00000300;
         if (cp0_we && cp0_addr == 5'd11) begin
            m_compare = cp0_wdata; m_flag = 0;
         end else if (m_count == m_compare) m_flag = 1;
         if (cp0_we && cp0_addr == 5'd9) m_count = cp0_wdata;
         else m_count = m_count + 1;
         m_we_prev = cp0_we;
         for (int i = SYNC_STAGES - 1; i > 0; i--) hw_d[i] = hw_d[i-1];
         hw_d[0] = hw_int;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         #2;
         check("model_int_take", {31'b0, int_take}, {31'b0, m_take});
         check("model_rdata", cp0_rdata, m_read(cp0_addr));
      end
   end

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      cp0_addr = a; cp0_we = 1'b1; cp0_wdata = d;
      @(negedge clk);
      cp0_we = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
      @(negedge clk);
      cp0_addr = a;
      #3 check(name, cp0_rdata, exp);
   endtask

   // Returns the number of negedges until int_take is seen, or -1 if it never rises.
   task automatic wait_take(input int max, output int n);
      n = 0;
      repeat (max) begin
         @(negedge clk);
         #1;
         n++;
         if (int_take === 1'b1) return;
      end
      n = -1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_on = 1'b1;

      rd(5'd12, 32'h0, "reset_status");
      rd(5'd13, 32'h0, "reset_cause");
      rd(5'd14, 32'h0, "reset_epc");
      hw_int = 6'h3F;
      wait_take(20, n);
      check("no_take_ie0", n, -1);
      hw_int = 6'h00;
      repeat (4) @(negedge clk);

      // First take: latency from hw_int edge.
      int_ok = 1'b1;
      pc_in = 32'h40;
      mtc0(5'd12, 32'h0000_0401);
      hw_int = 6'h01;
      wait_take(10, n);
      check("take_latency", n, SYNC_STAGES + 1);
      rd(5'd14, 32'h0000_0040, "epc_first");
      rd(5'd12, 32'h0000_0400, "status_after_take");
      rd(5'd13, 32'h0000_0400, "cause_after_take");

      // ISR with the level still held, re-enable subject to blackout.
      mtc0(5'd12, 32'h0000_0400);
      rd(5'd14, 32'h0000_0040, "isr_epc_read");
      pc_in = 32'h80;
      mtc0(5'd12, 32'h0000_0401);
      wait_take(6, n);
      check("retake_after_blackout", n, 2);
      rd(5'd14, 32'h0000_0080, "epc_retake");

      // Pipeline not interruptible, then interruptible.
      int_ok = 1'b0;
      mtc0(5'd12, 32'h0000_0401);
      wait_take(5, n);
      check("no_take_int_ok0", n, -1);
      pc_in = 32'hC0;
      int_ok = 1'b1;
      wait_take(3, n);
      check("take_when_int_ok", n, 1);
      rd(5'd14, 32'h0000_00C0, "epc_int_ok");

      // Software interrupt and register masking.
      hw_int = 6'h00;
      mtc0(5'd12, 32'h0);
      mtc0(5'd13, 32'hFFFF_FFFF);
      repeat (3) @(negedge clk);
      rd(5'd13, 32'h0000_0300, "cause_wmask");
      mtc0(5'd13, 32'h0000_0100);
      rd(5'd13, 32'h0000_0100, "cause_sw_ip0");
      pc_in = 32'h100;
      mtc0(5'd12, 32'h0000_0101);
      wait_take(6, n);
      check("sw_int_take", n, 2);
      rd(5'd14, 32'h0000_0100, "epc_sw");
      mtc0(5'd14, 32'hDEAD_BEEF);
      rd(5'd14, 32'h0000_0100, "epc_readonly");
      mtc0(5'd5, 32'h1234_5678);
      rd(5'd5, 32'h0, "unmapped_read");
      mtc0(5'd12, 32'hFFFF_FFFE);
      rd(5'd12, 32'h0000_FF00, "status_wmask");
`ifndef CP0_TIMER_EN
      mtc0(5'd9, 32'h1234_5678);
      rd(5'd9, 32'h0, "count_absent");
      rd(5'd11, 32'h0, "compare_absent");
`endif

      // Reset in the decision cycle aborts the take.
      repeat (3) @(negedge clk);
      pc_in = 32'h200;
      mtc0(5'd12, 32'h0000_0101);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1 check("reset_aborts_take", {31'b0, int_take}, 32'h0);
      rd(5'd12, 32'h0, "status_after_reset");
      rd(5'd14, 32'h0, "epc_after_reset");

      // A pulse between clock edges is never sampled.
      mtc0(5'd12, 32'h0000_0401);
      repeat (2) @(negedge clk);
      #1 hw_int = 6'h01;
      #2 hw_int = 6'h00;
      wait_take(6, n);
      check("glitch_no_take", n, -1);

`ifdef CP0_TIMER_EN
      mtc0(5'd12, 32'h0);
      mtc0(5'd9, 32'h0);
      mtc0(5'd11, 32'd10);
      mtc0(5'd12, 32'h0000_8001);
      wait_take(20, n);
      check("timer_take", n, 8);
      rd(5'd13, 32'h0000_8000, "timer_flag");
      mtc0(5'd11, 32'h0000_1000);
      rd(5'd13, 32'h0, "timer_flag_clear");
`endif

      repeat (3) @(negedge clk);
      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
